ncl_const_add_stage: RTL and testbench
======================================

# ncl_const_add_stage

Clocked, parametrised successor to the dual-rail half-adder-with-constant cell used in the NCL multiplier datapath. It adds a compile-time constant to a WIDTH-bit dual-rail operand and returns a dual-rail sum and carry-out. The stage runs the four-phase DATA/NULL wavefront protocol with a registered completion acknowledge. It adds illegal-codeword detection and a wavefront counter, and sits between NCL pipeline stages where a synchronous sampling boundary is needed.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits (1..32)
- CONST, 1, constant addend, taken modulo 2^WIDTH
- CNT_W, 16, wavefront counter width

Dual-rail encoding for bit i of every bus: rail [2i+1] is logic-1, rail [2i] is logic-0. 00 is NULL, 01 is data 0, 10 is data 1, 11 is illegal.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- init_n  in  1  asynchronous, active-low reset
- a_in  in  2*WIDTH  dual-rail operand from upstream
- a_comp  out  1  completion to upstream: 1 = DATA held (request NULL), 0 = request DATA
- sum  out  2*WIDTH  dual-rail sum, registered
- carryout  out  2  dual-rail carry-out, registered
- sum_comp  in  1  completion from downstream: 1 = downstream holds DATA (request NULL), 0 = request DATA
- err  out  1  sticky illegal-codeword flag
- tok_cnt  out  CNT_W  count of DATA wavefronts emitted

## Operation
- Input classification, per cycle:
  - complete: every bit is 01 or 10
  - null: every bit is 00
  - illegal: any bit is 11
  - otherwise partial
- State NULL_OUT, entered on reset:
  - sum and carryout are all-zero (NULL); a_comp=0
  - moves to DATA_OUT when a_in is complete, not illegal, and sum_comp=0
- State DATA_OUT:
  - sum and carryout hold the computed DATA codeword; a_comp=1
  - moves to NULL_OUT when a_in is null and sum_comp=1
- Arithmetic on the capture edge:
  - v = a + (CONST mod 2^WIDTH), computed WIDTH+1 bits wide
  - sum = v[WIDTH-1:0]
  - carryout = v[WIDTH]
  - both are dual-rail encoded
- Holding: partial input, or a sum_comp value that does not match the state, leaves state and outputs unchanged (the stage waits indefinitely).
- Illegal input:
  - sets err=1, which stays set until reset
  - the word is never captured and the state does not change
  - does not block a later legal transition
- tok_cnt increments by 1 on each NULL_OUT→DATA_OUT transition and wraps from 2^CNT_W-1 to 0.
- Outputs never present a mixed or illegal codeword. sum and carryout switch together, all-NULL to all-DATA or back, on one edge.

## Timing
- Reset, asynchronous on init_n=0:
  - sum=0, carryout=0, a_comp=0, err=0, tok_cnt=0, state NULL_OUT
  - release is sampled synchronously; the first transition can happen on the first rising edge with init_n=1
- Latency: one cycle. Qualifying inputs sampled at edge N give new sum, carryout, a_comp and tok_cnt after edge N.
- Throughput: at most one DATA wavefront every 2 cycles (DATA then NULL).
- Simultaneous events:
  - complete-but-illegal input with sum_comp=0 sets err and takes no transition
  - in DATA_OUT, a_in returning to NULL while sum_comp=0 is held, with no change
- Reset asserted in DATA_OUT forces NULL outputs immediately, without waiting for a clock. The in-flight token is discarded and is not counted again.
- No combinational path from a_in or sum_comp to any output.

## Test plan
- WIDTH=8, CONST=1, sum_comp=0, a=0x05 (complete) → next edge: sum=0x06, carryout=0, a_comp=1, tok_cnt=1. Then a=NULL with sum_comp=1 → next edge: sum all-zero, a_comp=0.
- a=0xFF → sum=0x00, carryout=1. With CONST=0x80 and a=0x90 → sum=0x10, carryout=1.
- Partial a (bit 7 NULL, other bits DATA) held 5 cycles → no change. Completing bit 7 → capture on the next edge.
- Complete a with sum_comp=1 held → no capture. Dropping sum_comp to 0 → capture one edge later.
- a bit 3 driven 11 → err=1 and no capture. A later legal a=0x10 → sum=0x11, err still 1.
- CNT_W=4, 17 full DATA/NULL cycles → tok_cnt=1. Separately, init_n=0 mid-DATA_OUT → outputs NULL immediately, tok_cnt=0, err=0.

Source files
------------

// File: rtl/ncl_const_add_stage.sv
// Clocked dual-rail stage: adds a compile-time constant to a NCL operand and
// returns the dual-rail sum and carry-out under the four-phase DATA/NULL protocol.
module ncl_const_add_stage #(
  parameter int WIDTH = 8,
  parameter int CONST = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic [2*WIDTH-1:0]   a_in,
  output logic                 a_comp,
  output logic [2*WIDTH-1:0]   sum,
  output logic [1:0]           carryout,
  input  logic                 sum_comp,
  output logic                 err,
  output logic [CNT_W-1:0]     tok_cnt
);

  typedef enum logic {
    NULL_OUT = 1'b0,
    DATA_OUT = 1'b1
  } state_e;

  // Constant reduced modulo 2^WIDTH, zero-extended by one bit for the carry.
  localparam logic [WIDTH-1:0] CONST_M   = CONST[WIDTH-1:0];
  localparam logic [WIDTH:0]   CONST_EXT = {1'b0, CONST_M};

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   sum_q, sum_d;
  logic [1:0]           carry_q, carry_d;
  logic                 a_comp_q, a_comp_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     tok_cnt_q, tok_cnt_d;

  logic                 in_complete;
  logic                 in_null;
  logic                 in_illegal;
  logic [WIDTH-1:0]     a_val;
  logic [WIDTH:0]       add_v;
  logic [2*WIDTH-1:0]   sum_data;
  logic [1:0]           carry_data;

  // Per-cycle classification of the incoming wavefront and decode of its value.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_complete = 1'b1;
    in_null     = 1'b1;
    in_illegal  = 1'b0;
    a_val       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_val[i] = a_in[2*i+1];
      if (a_in[2*i+1] || a_in[2*i]) begin
        in_null = 1'b0;
      end else begin
        in_complete = 1'b0;
      end
      if (a_in[2*i+1] && a_in[2*i]) begin
        in_illegal  = 1'b1;
        in_complete = 1'b0;
      end
    end
  end

  // Arithmetic and dual-rail encoding of the candidate DATA codeword.
  always_comb begin
    add_v    = {1'b0, a_val} + CONST_EXT;
    sum_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_data[2*i+1] = add_v[i];
      sum_data[2*i]   = ~add_v[i];
    end
    carry_data = {add_v[WIDTH], ~add_v[WIDTH]};
  end

  // Next-state logic. Anything not matching a transition rule holds the stage.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    a_comp_d  = a_comp_q;
    err_d     = err_q | in_illegal;
    tok_cnt_d = tok_cnt_q;
    unique case (state_q)
      NULL_OUT: begin
        if (in_complete && !in_illegal && !sum_comp) begin
          state_d   = DATA_OUT;
          sum_d     = sum_data;
          carry_d   = carry_data;
          a_comp_d  = 1'b1;
          tok_cnt_d = tok_cnt_q + CNT_W'(1);
        end
      end
      DATA_OUT: begin
        if (in_null && sum_comp) begin
          state_d  = NULL_OUT;
          sum_d    = '0;
          carry_d  = '0;
          a_comp_d = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so a
  // mid-DATA reset drops the outputs to NULL without waiting for a clock edge.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= NULL_OUT;
      sum_q     <= '0;
      carry_q   <= '0;
      a_comp_q  <= 1'b0;
      err_q     <= 1'b0;
      tok_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      a_comp_q  <= a_comp_d;
      err_q     <= err_d;
      tok_cnt_q <= tok_cnt_d;
    end
  end

  assign a_comp   = a_comp_q;
  assign sum      = sum_q;
  assign carryout = carry_q;
  assign err      = err_q;
  assign tok_cnt  = tok_cnt_q;

endmodule

// File: tb/tb_ncl_const_add_stage.sv
// Self-checking bench for ncl_const_add_stage: three instances share one input
// stream (CONST=1, CONST=0x80, CNT_W=4) and are compared against a wavefront-level model.
module tb_ncl_const_add_stage;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        sum_comp = 1'b0;
  logic [15:0] a_in = '0;

  logic        a_comp, a_comp_b, a_comp_c;
  logic [15:0] sum, sum_b, sum_c;
  logic [1:0]  co, co_b, co_c;
  logic        err, err_b, err_c;
  logic [15:0] tok, tok_b;
  logic [3:0]  tok_c;

  int checks = 0;
  int errors = 0;

  // Model: whether the stage holds a DATA wavefront, its captured value, err, token count.
  bit m_data = 1'b0;
  bit m_err = 1'b0;
  int m_val = 0;
  int m_tok = 0;

  always #5 clk = ~clk;

  ncl_const_add_stage #(.WIDTH(8), .CONST(1), .CNT_W(16)) dut (
    .clk(clk), .init_n(init_n), .a_in(a_in), .a_comp(a_comp), .sum(sum),
    .carryout(co), .sum_comp(sum_comp), .err(err), .tok_cnt(tok));

  ncl_const_add_stage #(.WIDTH(8), .CONST(8'h80), .CNT_W(16)) dut_c80 (
    .clk(clk), .init_n(init_n), .a_in(a_in), .a_comp(a_comp_b), .sum(sum_b),
    .carryout(co_b), .sum_comp(sum_comp), .err(err_b), .tok_cnt(tok_b));

  ncl_const_add_stage #(.WIDTH(8), .CONST(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .init_n(init_n), .a_in(a_in), .a_comp(a_comp_c), .sum(sum_c),
    .carryout(co_c), .sum_comp(sum_comp), .err(err_c), .tok_cnt(tok_c));

  function automatic logic [15:0] enc8(int v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = ((v >> i) & 1) != 0 ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] exp_sum(int c);
    if (!m_data) return '0;
    return enc8((m_val + (c & 255)) & 255);
  endfunction

  function automatic logic [1:0] exp_carry(int c);
    if (!m_data) return 2'b00;
    return (((m_val + (c & 255)) >> 8) & 1) != 0 ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_data = 1'b0;
    m_err  = 1'b0;
    m_val  = 0;
    m_tok  = 0;
  endtask

  // Apply the protocol rules to the inputs present just before the coming edge.
  task automatic model_edge();
    int n_data = 0;
    int n_null = 0;
    int n_ill  = 0;
    int val    = 0;
    for (int i = 0; i < 8; i++) begin
      case (a_in[2*i +: 2])
        2'b00: n_null++;
        2'b01: n_data++;
        2'b10: begin n_data++; val += (1 << i); end
        default: n_ill++;
      endcase
    end
    if (n_ill > 0) m_err = 1'b1;
    if (!m_data) begin
      if (n_data == 8 && !sum_comp) begin
        m_data = 1'b1;
        m_val  = val;
        m_tok++;
      end
    end else if (n_null == 8 && sum_comp) begin
      m_data = 1'b0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_data(int v);
    a_in = enc8(v);
    sum_comp = 1'b0;
    step();
  endtask

  task automatic do_null();
    a_in = '0;
    sum_comp = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    init_n = 1'b0;
    a_in = '0;
    sum_comp = 1'b0;
    model_reset();
    #12;
    init_n = 1'b1;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    model_reset();
    #3;
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want %h", sum, 16'h0000); end
    checks++; if (co !== 2'b00) begin errors++; $display("FAIL reset_carry got %b want 00", co); end
    checks++; if (a_comp !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_comp_err got %b%b want 00", a_comp, err); end
    checks++; if (tok !== 16'd0 || tok_c !== 4'd0) begin errors++; $display("FAIL reset_tok got %0d/%0d want 0/0", tok, tok_c); end
    #9;
    init_n = 1'b1;
    step();
    step();
    checks++; if (sum !== 16'h0000 || a_comp !== 1'b0) begin errors++; $display("FAIL reset_idle got sum=%h comp=%b want 0000/0", sum, a_comp); end
  endtask

  task automatic test_basic();
    do_data(8'h05);
    checks++; if (sum !== enc8(8'h06)) begin errors++; $display("FAIL basic_sum got %h want %h", sum, enc8(8'h06)); end
    checks++; if (co !== 2'b01) begin errors++; $display("FAIL basic_carry got %b want 01", co); end
    checks++; if (a_comp !== 1'b1) begin errors++; $display("FAIL basic_comp got %b want 1", a_comp); end
    checks++; if (tok !== 16'd1) begin errors++; $display("FAIL basic_tok got %0d want 1", tok); end
    checks++; if (sum_b !== enc8(8'h85) || co_b !== 2'b01) begin errors++; $display("FAIL basic_c80 got %h/%b want %h/01", sum_b, co_b, enc8(8'h85)); end
    do_null();
    checks++; if (sum !== 16'h0000 || co !== 2'b00 || a_comp !== 1'b0) begin errors++; $display("FAIL basic_null got %h/%b/%b want 0000/00/0", sum, co, a_comp); end
  endtask

  task automatic test_overflow();
    do_data(8'hFF);
    checks++; if (sum !== enc8(8'h00) || co !== 2'b10) begin errors++; $display("FAIL ovf_ff got %h/%b want %h/10", sum, co, enc8(8'h00)); end
    do_null();
    do_data(8'h90);
    checks++; if (sum_b !== enc8(8'h10) || co_b !== 2'b10) begin errors++; $display("FAIL ovf_c80 got %h/%b want %h/10", sum_b, co_b, enc8(8'h10)); end
    checks++; if (sum !== enc8(8'h91) || co !== 2'b01) begin errors++; $display("FAIL ovf_c1 got %h/%b want %h/01", sum, co, enc8(8'h91)); end
    do_null();
  endtask

  task automatic test_partial();
    a_in = enc8(8'h55);
    a_in[15:14] = 2'b00;
    sum_comp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (sum !== 16'h0000 || a_comp !== 1'b0) begin errors++; $display("FAIL partial_hold%0d got %h/%b want 0000/0", i, sum, a_comp); end
    end
    a_in[15:14] = 2'b10;
    step();
    checks++; if (sum !== enc8(8'hD6) || a_comp !== 1'b1) begin errors++; $display("FAIL partial_capture got %h/%b want %h/1", sum, a_comp, enc8(8'hD6)); end
    do_null();
  endtask

  task automatic test_sum_comp_hold();
    a_in = enc8(8'h3C);
    sum_comp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_comp !== 1'b0 || sum !== 16'h0000) begin errors++; $display("FAIL scomp_hold%0d got %b/%h want 0/0000", i, a_comp, sum); end
    end
    sum_comp = 1'b0;
    step();
    checks++; if (sum !== enc8(8'h3D) || a_comp !== 1'b1) begin errors++; $display("FAIL scomp_capture got %h/%b want %h/1", sum, a_comp, enc8(8'h3D)); end
    a_in = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (sum !== enc8(8'h3D) || a_comp !== 1'b1) begin errors++; $display("FAIL scomp_datahold%0d got %h/%b want %h/1", i, sum, a_comp, enc8(8'h3D)); end
    end
    sum_comp = 1'b1;
    step();
    checks++; if (sum !== 16'h0000 || a_comp !== 1'b0) begin errors++; $display("FAIL scomp_release got %h/%b want 0000/0", sum, a_comp); end
  endtask

  task automatic test_illegal();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_pre got %b want 0", err); end
    a_in = enc8(8'h10);
    a_in[7:6] = 2'b11;
    sum_comp = 1'b0;
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", err); end
    checks++; if (a_comp !== 1'b0 || sum !== 16'h0000) begin errors++; $display("FAIL illegal_nocap got %b/%h want 0/0000", a_comp, sum); end
    a_in = enc8(8'h10);
    step();
    checks++; if (sum !== enc8(8'h11) || err !== 1'b1) begin errors++; $display("FAIL illegal_recover got %h/%b want %h/1", sum, err, enc8(8'h11)); end
    do_null();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int mode;
      int b;
      mode = $urandom_range(0, 9);
      b = $urandom_range(0, 7);
      if (mode <= 3) begin
        a_in = enc8($urandom_range(0, 255));
      end else if (mode <= 6) begin
        a_in = '0;
      end else if (mode <= 8) begin
        a_in = enc8($urandom_range(0, 255));
        a_in[2*b +: 2] = 2'b00;
      end else begin
        a_in = enc8($urandom_range(0, 255));
        a_in[2*b +: 2] = 2'b11;
      end
      sum_comp = 1'($urandom_range(0, 1));
      step();
      checks++; if (sum !== exp_sum(1) || co !== exp_carry(1)) begin errors++; $display("FAIL rand%0d_sum got %h/%b want %h/%b", n, sum, co, exp_sum(1), exp_carry(1)); end
      checks++; if (sum_b !== exp_sum(8'h80) || co_b !== exp_carry(8'h80)) begin errors++; $display("FAIL rand%0d_c80 got %h/%b want %h/%b", n, sum_b, co_b, exp_sum(8'h80), exp_carry(8'h80)); end
      checks++; if (a_comp !== m_data || err !== m_err) begin errors++; $display("FAIL rand%0d_ctl got %b%b want %b%b", n, a_comp, err, m_data, m_err); end
      checks++; if (tok !== 16'(m_tok) || tok_c !== 4'(m_tok)) begin errors++; $display("FAIL rand%0d_tok got %0d/%0d want %0d", n, tok, tok_c, m_tok); end
    end
    a_in = '0;
    sum_comp = 1'b1;
    step();
  endtask

  task automatic test_back_to_back_wrap();
    apply_reset();
    for (int n = 0; n < 17; n++) begin
      do_data($urandom_range(0, 255));
      checks++; if (sum !== exp_sum(1) || a_comp !== 1'b1) begin errors++; $display("FAIL b2b%0d_data got %h/%b want %h/1", n, sum, a_comp, exp_sum(1)); end
      do_null();
    end
    checks++; if (tok_c !== 4'd1) begin errors++; $display("FAIL wrap_tok4 got %0d want 1", tok_c); end
    checks++; if (tok !== 16'd17) begin errors++; $display("FAIL wrap_tok16 got %0d want 17", tok); end
  endtask

  task automatic test_reset_mid_data();
    a_in = enc8(8'h22);
    a_in[1:0] = 2'b11;
    sum_comp = 1'b0;
    step();
    do_data(8'h42);
    checks++; if (a_comp !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b%b want 11", a_comp, err); end
    #2;
    init_n = 1'b0;
    #1;
    checks++; if (sum !== 16'h0000 || co !== 2'b00 || a_comp !== 1'b0) begin errors++; $display("FAIL midrst_null got %h/%b/%b want 0000/00/0", sum, co, a_comp); end
    checks++; if (tok !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL midrst_tok_err got %0d/%b want 0/0", tok, err); end
    model_reset();
    a_in = '0;
    #2;
    init_n = 1'b1;
    do_data(8'h07);
    checks++; if (sum !== enc8(8'h08) || tok !== 16'd1) begin errors++; $display("FAIL midrst_after got %h/%0d want %h/1", sum, tok, enc8(8'h08)); end
    do_null();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_partial();
    test_sum_comp_hold();
    test_illegal();
    test_random();
    test_back_to_back_wrap();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
